// File: rtl/alu_ops_pkg.sv
// Shared ALUControl encodings, multiply iteration count and EX-stage FSM states.
// Also consumed by the ALU control decoder.
package alu_ops_pkg;

   localparam logic [5:0] ALU_SLL    = 6'b000000;
   localparam logic [5:0] ALU_REGIMM = 6'b000001;  // BLTZ/BGEZ, split by RtSel
   localparam logic [5:0] ALU_SRL    = 6'b000010;
   localparam logic [5:0] ALU_JAL    = 6'b000011;
   localparam logic [5:0] ALU_BEQ    = 6'b000100;
   localparam logic [5:0] ALU_BNE    = 6'b000101;
   localparam logic [5:0] ALU_BLEZ   = 6'b000110;
   localparam logic [5:0] ALU_BGTZ   = 6'b000111;
   localparam logic [5:0] ALU_JR     = 6'b001000;
   localparam logic [5:0] ALU_MUL    = 6'b011000;
   localparam logic [5:0] ALU_ADD    = 6'b100000;
   localparam logic [5:0] ALU_SUB    = 6'b100010;
   localparam logic [5:0] ALU_AND    = 6'b100100;
   localparam logic [5:0] ALU_OR     = 6'b100101;
   localparam logic [5:0] ALU_XOR    = 6'b100110;
   localparam logic [5:0] ALU_NOR    = 6'b100111;
   localparam logic [5:0] ALU_SLT    = 6'b101010;

   localparam int unsigned MUL_ITERS = 32;

   typedef enum logic {
      StIdle,
      StMul
   } alu_state_e;

endpackage

// File: rtl/mul_iter32.sv
// Shift-add multiply engine: one multiplier bit per cycle, MUL_ITERS cycles after Load.
// Product presents the accumulator including the current cycle's partial product.
module mul_iter32
   import alu_ops_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Load,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Product,
   output logic             Last
);

   localparam int unsigned CntW = $clog2(MUL_ITERS);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [CntW-1:0]  cnt_q;
   logic             active_q;
   logic [WIDTH-1:0] sum;

   always_comb begin
      sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
      Product = sum;
      Last    = active_q && (cnt_q == CntW'(MUL_ITERS - 1));
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (Load) begin
         mcand_q  <= A;
         mplier_q <= B;
         acc_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         acc_q    <= sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CntW'(1);
         if (Last) begin
            active_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ex_alu_mc.sv
// Execute-stage ALU: single-cycle ops and branch decisions, plus a multi-cycle MUL
// that holds Busy high so the hazard unit can stall the front of the pipeline.
module ex_alu_mc
   import alu_ops_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [5:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       Shamt,
   input  logic             RtSel,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             BranchTaken,
   output logic             OutValid,
   output logic             Busy
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             branch_q, branch_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_br;
   logic [WIDTH-1:0] diff;
   logic             a_neg;
   logic             a_zero;
   logic             mul_load;
   logic [WIDTH-1:0] mul_product;
   logic             mul_last;

   mul_iter32 #(
      .WIDTH(WIDTH)
   ) u_mul (
      .Clk    (Clk),
      .Rst    (Rst),
      .Load   (mul_load),
      .A      (A),
      .B      (B),
      .Product(mul_product),
      .Last   (mul_last)
   );

   // Single-cycle datapath; branch codes report A-B as their result.
   always_comb begin
      diff    = A - B;
      a_neg   = A[WIDTH-1];
      a_zero  = (A == '0);
      alu_res = '0;
      alu_br  = 1'b0;
      case (ALUControl)
         ALU_ADD:    alu_res = A + B;
         ALU_SUB:    alu_res = diff;
         ALU_AND:    alu_res = A & B;
         ALU_OR:     alu_res = A | B;
         ALU_NOR:    alu_res = ~(A | B);
         ALU_XOR:    alu_res = A ^ B;
         ALU_SLL:    alu_res = B << Shamt;
         ALU_SRL:    alu_res = B >> Shamt;
         ALU_SLT:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         ALU_JR,
         ALU_JAL:    alu_res = A;
         ALU_BEQ: begin
            alu_res = diff;
            alu_br  = (A == B);
         end
         ALU_BNE: begin
            alu_res = diff;
            alu_br  = (A != B);
         end
         ALU_BGTZ: begin
            alu_res = diff;
            alu_br  = !a_neg && !a_zero;
         end
         ALU_BLEZ: begin
            alu_res = diff;
            alu_br  = a_neg || a_zero;
         end
         ALU_REGIMM: begin
            alu_res = diff;
            alu_br  = RtSel ? !a_neg : a_neg;
         end
         default: begin
            alu_res = '0;
            alu_br  = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      branch_d = branch_q;
      valid_d  = 1'b0;
      mul_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               if (ALUControl == ALU_MUL) begin
                  mul_load = 1'b1;
                  state_d  = StMul;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  branch_d = alu_br;
                  valid_d  = 1'b1;
               end
            end
         end
         StMul: begin
            if (mul_last) begin
               result_d = mul_product;
               zero_d   = (mul_product == '0);
               branch_d = 1'b0;
               valid_d  = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= StIdle;
         result_q <= '0;
         zero_q   <= 1'b0;
         branch_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         branch_q <= branch_d;
         valid_q  <= valid_d;
      end
   end

   // Decoded straight from state so an asynchronous reset drops it immediately.
   assign Busy        = (state_q == StMul);
   assign Result      = result_q;
   assign Zero        = zero_q;
   assign BranchTaken = branch_q;
   assign OutValid    = valid_q;

endmodule

// File: tb/tb_ex_alu_mc.sv
// Directed bench for ex_alu_mc: single-cycle ops, branches, back-to-back issue,
// the 32-cycle MUL sequence and an asynchronous abort mid-multiply.
module tb_ex_alu_mc;
   import alu_ops_pkg::*;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [5:0]  ALUControl;
   logic [31:0] A;
   logic [31:0] B;
   logic [4:0]  Shamt;
   logic        RtSel;
   logic [31:0] Result;
   logic        Zero;
   logic        BranchTaken;
   logic        OutValid;
   logic        Busy;

   int pass_cnt;
   int total_cnt;

   ex_alu_mc #(
      .WIDTH(32)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Start      (Start),
      .ALUControl (ALUControl),
      .A          (A),
      .B          (B),
      .Shamt      (Shamt),
      .RtSel      (RtSel),
      .Result     (Result),
      .Zero       (Zero),
      .BranchTaken(BranchTaken),
      .OutValid   (OutValid),
      .Busy       (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic rt);
      Start      = 1'b1;
      ALUControl = op;
      A          = a;
      B          = b;
      Shamt      = sh;
      RtSel      = rt;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      Start = 1'b0;
      ALUControl = '0;
      A = '0;
      B = '0;
      Shamt = '0;
      RtSel = 1'b0;
      tick();
      tick();
      Rst = 1'b0;
      tick();
      total_cnt++;
      if (Result !== 32'h0) $display("FAIL reset_result got %h want %h", Result, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if ({Zero, BranchTaken, OutValid, Busy} !== 4'b0000)
         $display("FAIL reset_flags got %b want 0000", {Zero, BranchTaken, OutValid, Busy});
      else pass_cnt++;
   endtask

   task automatic test_add();
      drive(ALU_ADD, 32'd7, 32'd5, 5'd0, 1'b0);
      tick();
      Start = 1'b0;
      total_cnt++;
      if (Result !== 32'd12) $display("FAIL add_result got %0d want 12", Result);
      else pass_cnt++;
      total_cnt++;
      if ({Zero, OutValid} !== 2'b01) $display("FAIL add_flags got %b want 01", {Zero, OutValid});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (OutValid !== 1'b0 || Result !== 32'd12)
         $display("FAIL add_hold got valid=%b result=%0d want valid=0 result=12", OutValid, Result);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      drive(ALU_SUB, 32'd5, 32'd5, 5'd0, 1'b0);
      tick();
      total_cnt++;
      if ({Result, Zero, OutValid} !== {32'd0, 1'b1, 1'b1})
         $display("FAIL b2b_sub got r=%h z=%b v=%b want r=0 z=1 v=1", Result, Zero, OutValid);
      else pass_cnt++;
      drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
      tick();
      Start = 1'b0;
      total_cnt++;
      if ({Result, Zero, OutValid} !== {32'd1, 1'b0, 1'b1})
         $display("FAIL b2b_slt got r=%h z=%b v=%b want r=1 z=0 v=1", Result, Zero, OutValid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (OutValid !== 1'b0) $display("FAIL b2b_idle got valid=%b want 0", OutValid);
      else pass_cnt++;
   endtask

   task automatic test_shift_branch();
      logic [5:0]  ops [10];
      logic [31:0] as  [10];
      logic [31:0] bs  [10];
      logic [4:0]  shs [10];
      logic        rts [10];
      logic [31:0] exp_r [10];
      logic        exp_br [10];
      ops = '{ALU_SLL, ALU_SRL, ALU_BLEZ, ALU_REGIMM, ALU_REGIMM,
              ALU_BEQ, ALU_BNE, ALU_BGTZ, 6'b111111, ALU_NOR};
      as  = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
              32'd4, 32'd4, 32'd5, 32'd9, 32'h0};
      bs  = '{32'h1, 32'h8000_0000, 32'h0, 32'h0, 32'h0,
              32'd4, 32'd4, 32'd2, 32'd3, 32'h0};
      shs = '{5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      rts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_r  = '{32'h8000_0000, 32'h0800_0000, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                 32'h0, 32'h0, 32'd3, 32'h0, 32'hFFFF_FFFF};
      exp_br = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(ops[i], as[i], bs[i], shs[i], rts[i]);
         tick();
         total_cnt++;
         if (Result !== exp_r[i] || BranchTaken !== exp_br[i] || Zero !== (exp_r[i] == 32'h0)
             || OutValid !== 1'b1)
            $display("FAIL vec%0d got r=%h br=%b z=%b v=%b want r=%h br=%b z=%b v=1", i,
                     Result, BranchTaken, Zero, OutValid, exp_r[i], exp_br[i],
                     (exp_r[i] == 32'h0));
         else pass_cnt++;
      end
      Start = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      int busy_cnt;
      int cycles;
      busy_cnt = 0;
      cycles = 0;
      drive(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
      tick();
      // Start stays high with an ADD that must wait until the MUL completes.
      drive(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b0);
      if (Busy === 1'b1) busy_cnt++;
      for (int j = 1; j <= 40; j++) begin
         tick();
         if (OutValid === 1'b1) begin
            cycles = j;
            break;
         end
         if (Busy === 1'b1) busy_cnt++;
      end
      total_cnt++;
      if (cycles !== 32) $display("FAIL mul_latency got %0d want 32", cycles);
      else pass_cnt++;
      total_cnt++;
      if (busy_cnt !== 32) $display("FAIL mul_busy_cycles got %0d want 32", busy_cnt);
      else pass_cnt++;
      total_cnt++;
      if (Result !== 32'hFFFF_FFEB || Zero !== 1'b0 || Busy !== 1'b0)
         $display("FAIL mul_result got r=%h z=%b busy=%b want r=ffffffeb z=0 busy=0",
                  Result, Zero, Busy);
      else pass_cnt++;
      tick();
      Start = 1'b0;
      total_cnt++;
      if (Result !== 32'd3 || OutValid !== 1'b1)
         $display("FAIL mul_followon_add got r=%0d v=%b want r=3 v=1", Result, OutValid);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_mul_abort();
      int valid_seen;
      int cycles;
      cycles = 0;
      drive(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
      tick();
      Start = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         tick();
         if (OutValid === 1'b1) begin
            cycles = j;
            break;
         end
      end
      total_cnt++;
      if (cycles !== 32 || Result !== 32'd1)
         $display("FAIL mul_ones got r=%h at %0d want r=1 at 32", Result, cycles);
      else pass_cnt++;
      tick();

      drive(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
      tick();
      Start = 1'b0;
      for (int j = 0; j < 10; j++) tick();
      #2;
      Rst = 1'b1;
      #1;
      total_cnt++;
      if (Busy !== 1'b0) $display("FAIL abort_busy_async got %b want 0", Busy);
      else pass_cnt++;
      tick();
      Rst = 1'b0;
      valid_seen = 0;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (OutValid === 1'b1) valid_seen++;
      end
      total_cnt++;
      if (valid_seen !== 0 || Result !== 32'h0)
         $display("FAIL abort_no_valid got pulses=%0d r=%h want pulses=0 r=0", valid_seen, Result);
      else pass_cnt++;
      drive(ALU_ADD, 32'd1, 32'd1, 5'd0, 1'b0);
      tick();
      Start = 1'b0;
      total_cnt++;
      if (Result !== 32'd2 || OutValid !== 1'b1)
         $display("FAIL abort_then_add got r=%0d v=%b want r=2 v=1", Result, OutValid);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_add();
      test_back_to_back();
      test_shift_branch();
      test_mul();
      test_mul_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ex_alu_mc.md
# ex_alu_mc

Execute-stage ALU for the pipelined MIPS datapath. It sits directly downstream of the ALU control decoder and consumes its 6-bit `ALUControl` code together with the operand pair from the ID/EX register. Most operations complete in a single registered cycle. `MUL` runs as a 32-iteration shift-add sequence and raises `Busy`, which the hazard unit uses to stall IF/ID/EX.

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is supported.
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Start` in 1: operand/op valid; accepted only when `Busy`=0.
- `ALUControl` in 6: operation code from the ALU control decoder.
- `A` in 32: rs operand.
- `B` in 32: rt operand, or the sign-extended immediate.
- `Shamt` in 5: shift amount for `SLL`/`SRL`.
- `RtSel` in 1: bit 0 of the rt field; selects BLTZ (0) or BGEZ (1) for code 000001.
- `Result` out 32: registered result.
- `Zero` out 1: registered; equals (`Result`==0).
- `BranchTaken` out 1: registered branch decision.
- `OutValid` out 1: one-cycle pulse; `Result`, `Zero` and `BranchTaken` are valid while it is high.
- `Busy` out 1: high while a `MUL` is iterating. It decodes combinationally from state.

## Operation
- **States:** `IDLE`, `MUL`.
- **Accept:** `Start`=1 in `IDLE` is an accept. `Start` while in `MUL` is ignored; the upstream stage holds because of `Busy`.
- **Single-cycle codes** (write `Result`, force `BranchTaken`=0):
  - 100000 ADD: A+B, wraps, no overflow trap.
  - 100010 SUB: A−B.
  - 100100 AND; 100101 OR; 100111 NOR; 100110 XOR.
  - 000000 SLL: B<<Shamt.
  - 000010 SRL: B>>Shamt, logical. Code 000010 is always SRL; J is resolved in ID and its EX result is don't-care.
  - 101010 SLT: signed A<B gives 1, otherwise 0.
  - 001000 JR and 000011 JAL: Result=A.
- **Branch codes** (Result=A−B, set `BranchTaken`):
  - 000100 BEQ: A==B.
  - 000101 BNE: A!=B.
  - 000111 BGTZ: signed A>0.
  - 000110 BLEZ: signed A<=0.
  - 000001: BLTZ (A<0) when `RtSel`=0; BGEZ (A>=0) when `RtSel`=1.
- **Unknown code:** Result=0, Zero=1, BranchTaken=0. `OutValid` still pulses.
- **MUL (011000):**
  - On accept, latch multiplicand=A, multiplier=B, accumulator=0, counter=0, then go to `MUL`.
  - Each `MUL` cycle: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - Result is the low 32 bits of A×B. These bits are identical for signed and unsigned operands.
- **Reset:** `Result`=0, `Zero`=0, `BranchTaken`=0, `OutValid`=0, state=`IDLE`, so `Busy`=0. All internal registers clear.

## Timing
- Accept on edge k, single-cycle op: outputs update at edge k+1, so `OutValid`=1 for the cycle after accept. Back-to-back accepts give `OutValid` every cycle.
- Accept on edge k, MUL:
  - `Busy`=1 from edge k until edge k+32, i.e. exactly 32 cycles.
  - At edge k+32 (counter==31): `Result` loads, `OutValid` pulses, and state returns to `IDLE`.
- `Start` in the cycle where `OutValid` is high (state `IDLE`) is accepted. There is no bubble.
- Outputs hold their last value while `OutValid`=0. `OutValid` never exceeds one cycle per accepted op.
- `Rst` asserted mid-MUL aborts immediately and asynchronously: `Busy` falls without waiting for an edge and no `OutValid` is produced. The first accept after `Rst` deasserts behaves as from reset.

## Structure
- Package `alu_ops_pkg`: localparams for every `ALUControl` code listed above, plus `MUL_ITERS`=32 and the state encoding. The ALU control decoder shares this package.
- Sub-module `mul_iter32`: the shift-add engine.
  - Ports: `Clk`, `Rst`, `Load`, `A`, `B`, `Product`, `Last`.
  - `ex_alu_mc` holds the FSM, the single-cycle datapath, and the output registers.

## Test plan
- Reset with `Start`=0 → all outputs 0, `Busy`=0. ADD A=7, B=5 → next cycle `Result`=12, `Zero`=0, `OutValid`=1 for one cycle.
- Back-to-back ops: SUB 5−5 then SLT A=−1, B=1 → `Result`=0 with `Zero`=1, then `Result`=1. Two consecutive `OutValid` pulses.
- Shifts and branches:
  - SLL B=1, Shamt=31 → 0x80000000.
  - SRL B=0x80000000, Shamt=4 → 0x08000000.
  - BLEZ A=0 → `BranchTaken`=1.
  - 000001 with A=−3, `RtSel`=1 → `BranchTaken`=0.
- MUL A=−3, B=7 → `Busy`=1 for exactly 32 cycles. `Result`=0xFFFFFFEB on the pulse 32 cycles after accept. A `Start` held during `Busy` is ignored; the following ADD is accepted in the `OutValid` cycle.
- MUL 0xFFFFFFFF×0xFFFFFFFF → `Result`=1. Repeat the same MUL with `Rst` pulsed at iteration 10 → `Busy` drops asynchronously, no `OutValid`, and a subsequent ADD 1+1 returns 2.
